// File: rtl/tlc59xx_model.sv
// tlc59xx_model: cycle-level model of a TLC5957-family LED driver (shift register,
// LAT command decode, GS1/GS2 latches in normal and poker modes, FC register).
module tlc59xx_model #(
    parameter int unsigned N_OUT   = 16,
    parameter int unsigned N_COLOR = 3,
    parameter int unsigned GS_BITS = 16
) (
    input  logic                             SCLK,
    input  logic                             rst,
    input  logic                             SIN,
    input  logic                             LAT,
    output logic                             SOUT,
    output logic [N_OUT*N_COLOR*GS_BITS-1:0] gs_disp,
    output logic                             disp_valid,
    output logic [47:0]                      fc_reg,
    output logic [4:0]                       poker_len,
    output logic                             cmd_err
);
    localparam int unsigned SHIFT_W     = N_OUT * N_COLOR;
    localparam int unsigned FC_W        = 48;
    localparam int unsigned PTR_W       = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned CI_W        = (N_COLOR > 1) ? $clog2(N_COLOR) : 1;
    localparam int unsigned BIT_W       = (GS_BITS > 1) ? $clog2(GS_BITS) : 1;
    localparam int unsigned PLN_W       = $clog2(GS_BITS + 1);
    localparam int unsigned SR_IW       = $clog2(SHIFT_W);
    localparam int unsigned FC_POKER    = 3;
    localparam int unsigned FC_XREFRESH = 42;

    localparam logic [FC_W-1:0]    FC_RESET = 48'h5802_0100_8040;
    localparam logic [GS_BITS-1:0] GS_ONES  = '1;

    localparam logic [3:0] CMD_WRTGS     = 4'd1;
    localparam logic [3:0] CMD_LATGS     = 4'd3;
    localparam logic [3:0] CMD_WRTFC     = 4'd5;
    localparam logic [3:0] CMD_LINERESET = 4'd7;
    localparam logic [3:0] CMD_READFC    = 4'd11;
    localparam logic [3:0] CMD_TMGRST    = 4'd13;
    localparam logic [3:0] CMD_FCWRTEN   = 4'd15;

    typedef logic [N_OUT-1:0][N_COLOR-1:0][GS_BITS-1:0] gs_t;

    // Reject geometries the shift register cannot serve (FC read-back, one output per write, 5-bit poker_len)
    generate
        if (SHIFT_W < FC_W || N_COLOR * GS_BITS > SHIFT_W || GS_BITS > 31) begin : g_bad_params
            $error("tlc59xx_model: unsupported N_OUT/N_COLOR/GS_BITS combination");
        end
    endgenerate

    logic [SHIFT_W-1:0] sr,      sr_n;
    logic [3:0]         cnt,     cnt_n;
    gs_t                gs1,     gs1_n;
    gs_t                gs2,     gs2_n;
    logic               dv_n;
    logic [FC_W-1:0]    fc_n;
    logic               fc_arm,  arm_n;
    logic [PTR_W-1:0]   ptr,     ptr_n;
    logic [PLN_W-1:0]   planes,  planes_n;
    logic [4:0]         plen_n;
    logic               err_n;
    logic               pend,    pend_n;
    logic               xfer,    xfer_n;

    logic               gs_wr;
    logic               gs_lat;
    logic               gs_line;
    logic [PLN_W-1:0]   planes_w;
    logic [BIT_W-1:0]   plane_idx;
    logic [GS_BITS-1:0] keep_mask;

    assign SOUT    = sr[SHIFT_W-1];
    assign gs_disp = gs2;

    // Next-state: shift, LAT counting, command decode, GS writes and the delayed GS1->GS2 transfer
    always_comb begin
        sr_n      = {sr[SHIFT_W-2:0], SIN};
        cnt_n     = LAT ? ((cnt == 4'd15) ? cnt : cnt + 4'd1) : 4'd0;
        gs1_n     = gs1;
        gs2_n     = gs2;
        dv_n      = 1'b0;
        fc_n      = fc_reg;
        arm_n     = fc_arm;
        ptr_n     = ptr;
        planes_n  = planes;
        plen_n    = poker_len;
        err_n     = cmd_err;
        pend_n    = pend;
        xfer_n    = 1'b0;
        gs_wr     = 1'b0;
        gs_lat    = 1'b0;
        gs_line   = 1'b0;
        planes_w  = planes;
        plane_idx = BIT_W'(GS_BITS - 1) - BIT_W'(planes);
        keep_mask = GS_ONES;

        // Transfer scheduled by last cycle's latch command
        if (xfer) begin
            gs2_n = gs1;
            dv_n  = 1'b1;
        end

        // Decode on the first low edge after LAT was high; writes use the pre-shift sr
        if (!LAT && cnt != 4'd0) begin
            case (cnt)
                CMD_WRTGS:     gs_wr = 1'b1;
                CMD_LATGS: begin
                    gs_wr  = 1'b1;
                    gs_lat = 1'b1;
                end
                CMD_LINERESET: begin
                    gs_wr   = 1'b1;
                    gs_line = 1'b1;
                end
                CMD_WRTFC: begin
                    if (fc_arm) begin
                        fc_n  = sr[FC_W-1:0];
                        arm_n = 1'b0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                CMD_READFC:    sr_n = SHIFT_W'(fc_reg);
                CMD_TMGRST: begin
                    ptr_n    = '0;
                    planes_n = '0;
                    pend_n   = 1'b0;
                end
                CMD_FCWRTEN:   arm_n = 1'b1;
                default:       err_n = 1'b1;
            endcase
        end

        // GS1 write, in the mode currently held in fc_reg
        if (gs_wr) begin
            if (!fc_reg[FC_POKER]) begin
                gs1_n[ptr] = sr[N_COLOR*GS_BITS-1:0];
                ptr_n      = (ptr == PTR_W'(N_OUT - 1)) ? '0 : ptr + PTR_W'(1);
                if (gs_lat || gs_line) begin
                    ptr_n = '0;
                end
            end else begin
                if (planes < PLN_W'(GS_BITS)) begin
                    for (int unsigned o = 0; o < N_OUT; o++) begin
                        for (int unsigned c = 0; c < N_COLOR; c++) begin
                            gs1_n[PTR_W'(o)][CI_W'(c)][plane_idx] = sr[SR_IW'(o * N_COLOR + c)];
                        end
                    end
                    planes_w = planes + PLN_W'(1);
                end else begin
                    err_n = 1'b1;
                end
                planes_n = planes_w;
                if (gs_lat || gs_line) begin
                    // Planes never written this frame read as zero
                    keep_mask = ~(GS_ONES >> planes_w);
                    for (int unsigned o = 0; o < N_OUT; o++) begin
                        for (int unsigned c = 0; c < N_COLOR; c++) begin
                            gs1_n[PTR_W'(o)][CI_W'(c)] = gs1_n[PTR_W'(o)][CI_W'(c)] & keep_mask;
                        end
                    end
                    plen_n   = 5'(planes_w);
                    planes_n = '0;
                end
            end

            if (gs_line) begin
                xfer_n = 1'b1;
                pend_n = 1'b0;
            end else if (gs_lat) begin
                if (fc_reg[FC_XREFRESH]) begin
                    xfer_n = 1'b1;
                end else begin
                    pend_n = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous power-on reset
    always_ff @(posedge SCLK) begin
        if (rst) begin
            sr         <= '0;
            cnt        <= '0;
            gs1        <= '0;
            gs2        <= '0;
            disp_valid <= 1'b0;
            fc_reg     <= FC_RESET;
            fc_arm     <= 1'b0;
            ptr        <= '0;
            planes     <= '0;
            poker_len  <= '0;
            cmd_err    <= 1'b0;
            pend       <= 1'b0;
            xfer       <= 1'b0;
        end else begin
            sr         <= sr_n;
            cnt        <= cnt_n;
            gs1        <= gs1_n;
            gs2        <= gs2_n;
            disp_valid <= dv_n;
            fc_reg     <= fc_n;
            fc_arm     <= arm_n;
            ptr        <= ptr_n;
            planes     <= planes_n;
            poker_len  <= plen_n;
            cmd_err    <= err_n;
            pend       <= pend_n;
            xfer       <= xfer_n;
        end
    end

endmodule

// File: tb/tb_tlc59xx_model.sv
// tb_tlc59xx_model: randomized scenarios against a behavioural model of the driver.
module tb_tlc59xx_model;
    localparam int N_OUT   = 16;
    localparam int N_COLOR = 3;
    localparam int GS_BITS = 16;
    localparam int DISP_W  = N_OUT * N_COLOR * GS_BITS;

    localparam logic [47:0] FC_DEF  = 48'h5802_0100_8040;
    localparam logic [47:0] FC_NORM = 48'h5C02_0100_8040;
    localparam logic [47:0] FC_POKE = 48'h5C02_0100_8048;

    logic              SCLK = 1'b0;
    logic              rst  = 1'b0;
    logic              SIN  = 1'b0;
    logic              LAT  = 1'b0;
    logic              SOUT;
    logic [DISP_W-1:0] gs_disp;
    logic              disp_valid;
    logic [47:0]       fc_reg;
    logic [4:0]        poker_len;
    logic              cmd_err;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [GS_BITS-1:0] m_gs1  [N_OUT][N_COLOR];
    logic [GS_BITS-1:0] m_disp [N_OUT][N_COLOR];
    logic [47:0]        m_fc;
    bit                 m_arm;
    bit                 m_err;
    int                 m_ptr;
    int                 m_planes;
    int                 m_plen;

    tlc59xx_model #(.N_OUT(N_OUT), .N_COLOR(N_COLOR), .GS_BITS(GS_BITS)) dut (
        .SCLK       (SCLK),
        .rst        (rst),
        .SIN        (SIN),
        .LAT        (LAT),
        .SOUT       (SOUT),
        .gs_disp    (gs_disp),
        .disp_valid (disp_valid),
        .fc_reg     (fc_reg),
        .poker_len  (poker_len),
        .cmd_err    (cmd_err)
    );

    always #5 SCLK = ~SCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge SCLK);
        #1;
    endtask

    task automatic m_reset();
        for (int o = 0; o < N_OUT; o++) begin
            for (int c = 0; c < N_COLOR; c++) begin
                m_gs1[o][c]  = '0;
                m_disp[o][c] = '0;
            end
        end
        m_fc     = FC_DEF;
        m_arm    = 0;
        m_err    = 0;
        m_ptr    = 0;
        m_planes = 0;
        m_plen   = 0;
    endtask

    function automatic logic [DISP_W-1:0] exp_disp();
        logic [DISP_W-1:0] v;
        v = '0;
        for (int o = 0; o < N_OUT; o++) begin
            for (int c = 0; c < N_COLOR; c++) begin
                v[(o*N_COLOR+c)*GS_BITS +: GS_BITS] = m_disp[o][c];
            end
        end
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        LAT = 1'b0;
        SIN = 1'($urandom);
        tick();
        rst = 1'b0;
        m_reset();
    endtask

    // Shift 48 bits MSB first with LAT high for the last 'tail' bits, then the LAT-low decode edge
    task automatic shift_word(input logic [47:0] w, input int tail);
        for (int i = 47; i >= 0; i--) begin
            SIN = w[i];
            LAT = (i < tail);
            tick();
        end
        LAT = 1'b0;
        SIN = 1'($urandom);
        tick();
    endtask

    // Command that carries no data: n LAT-high edges then the decode edge
    task automatic cmd(input int n);
        for (int i = 0; i < n; i++) begin
            LAT = 1'b1;
            SIN = 1'($urandom);
            tick();
        end
        LAT = 1'b0;
        tick();
    endtask

    task automatic arm();
        cmd(15);
        m_arm = 1;
    endtask

    task automatic fc_cmd(input logic [47:0] w);
        shift_word(w, 5);
        if (m_arm) begin
            m_fc  = w;
            m_arm = 0;
        end else begin
            m_err = 1;
        end
    endtask

    // GS command (kind = LAT count 1/3/7) and its effect on the model
    task automatic gs_cmd(input logic [47:0] w, input int kind, output bit xf);
        shift_word(w, kind);
        xf = 0;
        if (!m_fc[3]) begin
            for (int c = 0; c < N_COLOR; c++) m_gs1[m_ptr][c] = w[c*GS_BITS +: GS_BITS];
            m_ptr = (m_ptr + 1) % N_OUT;
            if (kind != 1) m_ptr = 0;
        end else begin
            if (m_planes < GS_BITS) begin
                for (int o = 0; o < N_OUT; o++)
                    for (int c = 0; c < N_COLOR; c++)
                        m_gs1[o][c][GS_BITS-1-m_planes] = w[o*N_COLOR+c];
                m_planes++;
            end else begin
                m_err = 1;
            end
            if (kind != 1) begin
                m_plen = m_planes;
                for (int o = 0; o < N_OUT; o++)
                    for (int c = 0; c < N_COLOR; c++)
                        for (int b = 0; b < GS_BITS - m_planes; b++) m_gs1[o][c][b] = 1'b0;
                m_planes = 0;
            end
        end
        if (kind == 7 || (kind == 3 && m_fc[42])) xf = 1;
        if (xf) m_disp = m_gs1;
    endtask

    // One frame: nwr-1 WRTGS then a final command of 'kind'; pat 0=random 1=index 2=all-ones
    task automatic run_frame(input string tag, input int pat, input int nwr, input int kind);
        logic [47:0] w;
        bit xf;
        xf = 0;
        for (int j = 0; j < nwr; j++) begin
            case (pat)
                1:       w = {16'(j + 32), 16'(j + 16), 16'(j)};
                2:       w = '1;
                default: w = 48'({$urandom(), $urandom()});
            endcase
            gs_cmd(w, (j == nwr - 1) ? kind : 1, xf);
        end
        checks++;
        if (disp_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s dv_on_cmd_edge: got %0b expected 0", tag, disp_valid);
        end
        tick();
        checks++;
        if (disp_valid !== xf) begin
            failures++;
            $display("FAIL %s dv_pulse: got %0b expected %0b", tag, disp_valid, xf);
        end
        checks++;
        if (gs_disp !== exp_disp()) begin
            failures++;
            $display("FAIL %s gs_disp: got %h expected %h", tag, gs_disp, exp_disp());
        end
        checks++;
        if (cmd_err !== m_err || poker_len !== 5'(m_plen) || fc_reg !== m_fc) begin
            failures++;
            $display("FAIL %s status: got err=%0b len=%0d fc=%h expected err=%0b len=%0d fc=%h",
                     tag, cmd_err, poker_len, fc_reg, m_err, m_plen, m_fc);
        end
        tick();
        checks++;
        if (disp_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s dv_width: got %0b expected 0", tag, disp_valid);
        end
    endtask

    task automatic test_reset();
        SIN = 1'b1;
        LAT = 1'b1;
        tick();
        do_reset();
        checks++;
        if (fc_reg !== FC_DEF || SOUT !== 1'b0 || gs_disp !== '0 || cmd_err !== 1'b0
            || disp_valid !== 1'b0 || poker_len !== 5'd0) begin
            failures++;
            $display("FAIL reset: got fc=%h sout=%0b gs_nz=%0b err=%0b dv=%0b len=%0d expected fc=%h rest zero",
                     fc_reg, SOUT, |gs_disp, cmd_err, disp_valid, poker_len, FC_DEF);
        end
    endtask

    task automatic test_fc_write();
        logic [47:0] r;
        do_reset();
        arm();
        fc_cmd(FC_NORM);
        checks++;
        if (fc_reg !== FC_NORM || cmd_err !== 1'b0) begin
            failures++;
            $display("FAIL fc_armed: got fc=%h err=%0b expected fc=%h err=0", fc_reg, cmd_err, FC_NORM);
        end
        r = 48'({$urandom(), $urandom()}) ^ FC_NORM | 48'h1;
        fc_cmd(r);
        checks++;
        if (fc_reg !== FC_NORM || cmd_err !== 1'b1) begin
            failures++;
            $display("FAIL fc_unarmed: got fc=%h err=%0b expected fc=%h err=1", fc_reg, cmd_err, FC_NORM);
        end
        // Saturated LAT count still means FCWRTEN; the arm survives TMGRST
        do_reset();
        cmd(20);
        m_arm = 1;
        cmd(13);
        r = 48'({$urandom(), $urandom()});
        fc_cmd(r);
        checks++;
        if (fc_reg !== r || cmd_err !== 1'b0) begin
            failures++;
            $display("FAIL fc_sat_arm: got fc=%h err=%0b expected fc=%h err=0", fc_reg, cmd_err, r);
        end
    endtask

    task automatic test_normal();
        logic [47:0] seg;
        do_reset();
        arm();
        fc_cmd(FC_NORM);
        run_frame("normal_idx", 1, 16, 3);
        for (int i = 0; i < N_OUT; i++) begin
            seg = gs_disp[i*48 +: 48];
            checks++;
            if (seg !== {16'(i + 32), 16'(i + 16), 16'(i)}) begin
                failures++;
                $display("FAIL normal_out%0d: got %h expected %h", i, seg,
                         {16'(i + 32), 16'(i + 16), 16'(i)});
            end
        end
        run_frame("normal_rand_a", 0, int'($urandom_range(1, 20)), 3);
        run_frame("normal_rand_b", 0, int'($urandom_range(1, 20)), 7);
        arm();
        fc_cmd(FC_DEF);
        run_frame("normal_noxref", 0, int'($urandom_range(1, 16)), 3);
        run_frame("normal_lreset", 0, int'($urandom_range(1, 16)), 7);
    endtask

    task automatic test_poker();
        bit xf;
        do_reset();
        arm();
        fc_cmd(FC_NORM);
        // Normal writes before the mode switch leave ptr mid-frame
        for (int j = 0; j < 3; j++) gs_cmd(48'({$urandom(), $urandom()}), 1, xf);
        arm();
        fc_cmd(FC_POKE);
        run_frame("poker_ones", 2, 10, 3);
        checks++;
        if (poker_len !== 5'd10 || gs_disp !== {(N_OUT*N_COLOR){16'hFFC0}}) begin
            failures++;
            $display("FAIL poker_ones_const: got len=%0d gs=%h expected len=10 all FFC0", poker_len, gs_disp);
        end
        run_frame("poker_rand", 0, int'($urandom_range(1, 16)), 7);
        run_frame("poker_full", 0, 16, 3);
        run_frame("poker_over", 0, 17, 3);
        arm();
        fc_cmd(FC_NORM);
        run_frame("poker_back_norm", 0, 5, 3);
    endtask

    task automatic test_readfc();
        logic [47:0] r;
        logic [47:0] got;
        do_reset();
        r = 48'({$urandom(), $urandom()});
        arm();
        fc_cmd(r);
        cmd(11);
        got[47] = SOUT;
        for (int i = 46; i >= 0; i--) begin
            LAT = 1'b0;
            SIN = 1'($urandom);
            tick();
            got[i] = SOUT;
        end
        checks++;
        if (got !== r) begin
            failures++;
            $display("FAIL readfc_stream: got %h expected %h", got, r);
        end
    endtask

    task automatic test_bad_cmd();
        do_reset();
        arm();
        fc_cmd(FC_NORM);
        run_frame("bad_pre", 0, 7, 7);
        cmd(9);
        m_err = 1;
        checks++;
        if (cmd_err !== 1'b1 || fc_reg !== m_fc || gs_disp !== exp_disp() || disp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bad_cmd: got err=%0b fc=%h dv=%0b expected err=1 fc=%h dv=0",
                     cmd_err, fc_reg, disp_valid, m_fc);
        end
        tick();
        checks++;
        if (disp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bad_cmd_dv: got %0b expected 0", disp_valid);
        end
        run_frame("bad_post", 0, 5, 7);
    endtask

    task automatic test_reset_mid_frame();
        bit xf;
        do_reset();
        arm();
        fc_cmd(FC_POKE);
        for (int j = 0; j < 4; j++) gs_cmd(48'({$urandom(), $urandom()}), 1, xf);
        for (int i = 0; i < 20; i++) begin
            SIN = 1'($urandom);
            LAT = (i > 17);
            tick();
        end
        do_reset();
        checks++;
        if (fc_reg !== FC_DEF || gs_disp !== '0 || disp_valid !== 1'b0 || poker_len !== 5'd0
            || SOUT !== 1'b0 || cmd_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst: got fc=%h gs_nz=%0b dv=%0b len=%0d sout=%0b err=%0b expected reset values",
                     fc_reg, |gs_disp, disp_valid, poker_len, SOUT, cmd_err);
        end
        arm();
        fc_cmd(FC_POKE);
        run_frame("post_rst_poker", 0, 10, 3);
        // Reset on the transfer edge suppresses the pulse
        gs_cmd(48'({$urandom(), $urandom()}), 1, xf);
        gs_cmd(48'({$urandom(), $urandom()}), 3, xf);
        do_reset();
        checks++;
        if (disp_valid !== 1'b0 || gs_disp !== '0) begin
            failures++;
            $display("FAIL rst_on_xfer: got dv=%0b gs_nz=%0b expected dv=0 gs=0", disp_valid, |gs_disp);
        end
    endtask

    initial begin
        m_reset();
        tick();
        test_reset();
        test_fc_write();
        test_normal();
        test_poker();
        test_readfc();
        test_bad_cmd();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
